nios_adc_onchip_ram_pipelined: RTL and testbench
================================================

# nios_adc_onchip_ram_pipelined

Parametrised Avalon-MM on-chip RAM slave for the Nios ADC system. It replaces the fixed 32-bit × 80000-word single-port RAM. Width, depth and read latency are now set by parameters. It adds pipelined reads with `readdatavalid`, `waitrequest` back-pressure, a hardware zero-fill after reset, and optional per-byte parity. It sits on the Nios data master / ADC DMA interconnect as program and sample-buffer memory.

## Interface
Parameters:
- `DATA_W`, 32: data width in bits; a multiple of 8.
- `ADDR_W`, 17: word address width.
- `DEPTH`, 80000: number of words; must satisfy DEPTH ≤ 2^ADDR_W.
- `OUT_REG`, 1: 0 gives read latency 1; 1 adds an output register, giving latency 2.
- `CLEAR_ON_RESET`, 1: 1 zero-fills the array after reset; 0 skips the fill.

Ports:
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in ADDR_W: word address.
- `byteenable` in DATA_W/8: write byte lanes.
- `chipselect` in 1: slave select.
- `read` in 1: read request.
- `write` in 1: write request.
- `writedata` in DATA_W: write data.
- `readdata` out DATA_W: read data; valid only while `readdatavalid` is high.
- `readdatavalid` out 1: one-cycle pulse per accepted read.
- `waitrequest` out 1: high means the request is not accepted this cycle.
- `clken` in 1: global clock enable.
- `reset_req` in 1: reset-request stall, as in the existing memories.
- `init_done` out 1: high once the zero-fill has completed.
- `parity_err` out 1: sticky parity error; present only when the macro is defined.

## Operation
- FSM states:
  - CLEAR: writes 0 to addresses 0..DEPTH-1, one word per cycle; `waitrequest`=1.
  - RUN: normal access; entered after word DEPTH-1 is written.
  - If CLEAR_ON_RESET=0, the FSM goes straight to RUN and array contents are undefined.
- `init_done`=1 in RUN.
- Stall: `stall` = ~`clken` | `reset_req`. While stalled:
  - `waitrequest`=1 and no request is accepted.
  - The read pipeline and the clear counter freeze.
  - `readdatavalid` is held 0.
- Accept rule: a request is accepted when `chipselect` & (`read`|`write`) & ~`waitrequest`.
- Write: byte lanes with `byteenable`[i]=1 are updated. A write with `byteenable`=0 is accepted but changes nothing.
- Read and write asserted together: treated as a write; no `readdatavalid` is produced.
- Read-during-write to the same address in the same cycle cannot happen (single port). A read issued the cycle after a write returns the new data.
- Out-of-range address (≥ DEPTH): writes are dropped; reads return 0 with normal `readdatavalid` timing.
- Reset asserted mid-CLEAR or mid-read: all state is cleared immediately. In-flight reads are discarded (no `readdatavalid`). CLEAR restarts from address 0 after release.

## Timing
- Reset values:
  - `readdata`=0, `readdatavalid`=0, `waitrequest`=1, `init_done`=0, `parity_err`=0.
  - FSM = CLEAR, or RUN if CLEAR_ON_RESET=0.
- Zero-fill duration: DEPTH cycles from the first edge after `reset_n` rises. `waitrequest` falls on the cycle after the final clear write.
- Read latency: a read accepted at edge N raises `readdatavalid` at edge N+1+OUT_REG, excluding stalled cycles.
- Reads may be issued back-to-back every cycle; `readdatavalid` pulses come out in order with no gaps.
- Writes complete at the accepting edge; there is no response.
- A pipeline of 1+OUT_REG valid bits tracks outstanding reads. There is no read-side back-pressure; the master must always accept data.

## Configuration
- Macro: `NIOS_ADC_ONCHIP_RAM_PARITY_EN`.
- Defined:
  - Each byte stores one extra even-parity bit; the array becomes DATA_W + DATA_W/8 bits wide.
  - Parity is generated on write and checked when `readdatavalid` is asserted.
  - Any mismatch sets `parity_err`, which stays high until `reset_n`.
  - The zero-fill writes correct parity (all 0).
- Undefined: the array is DATA_W bits wide and the `parity_err` port is absent.

## Structure
- Package `nios_adc_onchip_ram_pkg`:
  - FSM state enum {CLEAR, RUN}.
  - Function `byte_parity(data)` returning DATA_W/8 bits.
  - Constant for the latency formula LAT = 1 + OUT_REG.
- Sub-module `nios_adc_ram_core`:
  - Inferred single-port synchronous RAM with per-lane write enables and clock enable.
  - Parameters: width and depth.
- The top level holds the FSM, the clear counter, the read-valid pipeline, the optional output register and the parity check.

## Test plan
- Reset, then wait with DEPTH=16, CLEAR_ON_RESET=1 → `waitrequest`=1 for 16 cycles, then 0; `init_done`=1; a read of address 5 returns 0x00000000.
- Write 0xDEADBEEF to address 3 with `byteenable`=4'b0101, then read address 3 → 0x00AD00EF. With OUT_REG=1, `readdatavalid` rises 2 cycles after accept; with OUT_REG=0, 1 cycle after.
- Back-to-back reads of addresses 0..3 (preloaded with 0x10..0x13) → four consecutive `readdatavalid` pulses carrying 0x10, 0x11, 0x12, 0x13 in order.
- `clken`=0 for 3 cycles mid-read → `waitrequest`=1 and no `readdatavalid` during the stall; data delivered after `clken` returns with latency extended by 3.
- Read of address 20 with DEPTH=16 → `readdata`=0 and `readdatavalid` asserted; a write to address 20 leaves addresses 0..15 unchanged.
- Macro defined: force-flip one stored parity bit at address 7, then read address 7 → `parity_err` goes to 1 on the `readdatavalid` cycle and stays 1 until `reset_n` is pulsed.

Source files
------------

// File: rtl/nios_adc_onchip_ram_pkg.sv
// Shared types and helpers for the pipelined Avalon-MM on-chip RAM.
// Optional byte parity is enabled by NIOS_ADC_ONCHIP_RAM_PARITY_EN.
package nios_adc_onchip_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int MAX_W    = 1024;
  localparam int LAT_BASE = 1;

  function automatic int read_lat(input int out_reg);
    return LAT_BASE + out_reg;
  endfunction

  function automatic logic [MAX_W/8-1:0] byte_parity(
    input logic [MAX_W-1:0] data
  );
    logic [MAX_W/8-1:0] p;
    for (int i = 0; i < MAX_W/8; i++) p[i] = ^data[8*i +: 8];
    return p;
  endfunction

endpackage

// File: rtl/nios_adc_ram_core.sv
// Inferred single-port synchronous RAM with per-lane writes.
// Read data is registered; ce freezes both array and read port.
module nios_adc_ram_core #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 80000,
  parameter int LANES = 4,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             ce,
  input  logic [LANES-1:0] we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam int LW = WIDTH / LANES;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // lane writes and registered read share the single address port
  always_ff @(posedge clk) begin
    if (ce) begin
      for (int i = 0; i < LANES; i++)
        if (we[i]) mem_q[addr][i*LW +: LW] <= wdata[i*LW +: LW];
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/nios_adc_onchip_ram_pipelined.sv
// Avalon-MM on-chip RAM: zero-fill, pipelined reads, stall.
// Byte parity when NIOS_ADC_ONCHIP_RAM_PARITY_EN is defined.
module nios_adc_onchip_ram_pipelined
  import nios_adc_onchip_ram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 17,
  parameter int DEPTH          = 80000,
  parameter int OUT_REG        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  input  logic                clken,
  input  logic                reset_req,
  output logic                init_done
`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
  ,
  output logic                parity_err
`endif
);

  localparam int NB  = DATA_W / 8;
  localparam int LAT = read_lat(OUT_REG);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
  localparam int SW  = DATA_W + NB;
`else
  localparam int SW  = DATA_W;
`endif
  localparam int LW  = SW / NB;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);
  localparam state_e RST_ST = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_q, clr_d;
  logic [LAT-1:0]  vld_q;
  logic            rng1_q;
  logic            stall, clearing, in_range;
  logic            acc, wr_acc, rd_acc;
  logic [NB-1:0]   ram_we;
  logic [AW-1:0]   ram_addr;
  logic [SW-1:0]   ram_wd, ram_rd;
  logic [DATA_W-1:0] s1_word, s1_data, out_data;

  assign stall    = ~clken | reset_req;
  assign in_range = {1'b0, address} < DEPTH_V;
  assign acc      = chipselect & (read | write) & ~waitrequest;
  assign wr_acc   = acc & write;
  assign rd_acc   = acc & read & ~write;

  // FSM state and clear counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_ST;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // next state: sweep one word per unstalled cycle, then run
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    unique case (state_q)
      CLEAR: begin
        if (!stall) begin
          clr_d = clr_q + 1'b1;
          if (clr_q == LAST) begin
            state_d = RUN;
            clr_d   = '0;
          end
        end
      end
      RUN:     state_d = RUN;
      default: state_d = RST_ST;
    endcase
  end

  // FSM outputs: bus handshake and clear-write select
  always_comb begin
    waitrequest = 1'b1;
    init_done   = 1'b0;
    clearing    = 1'b0;
    unique case (state_q)
      CLEAR: clearing = 1'b1;
      RUN: begin
        waitrequest = stall | ~reset_n;
        init_done   = reset_n;
      end
      default: clearing = 1'b0;
    endcase
  end

`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
  logic [MAX_W-1:0]   wd_ext, rd_ext;
  logic [MAX_W/8-1:0] wpar_all, rpar_all;
  logic [NB-1:0]      wpar, rpar, spar;
  logic               s1_mism, out_mism, err_q;
  assign wd_ext   = MAX_W'(writedata);
  assign wpar_all = byte_parity(wd_ext);
  assign wpar     = wpar_all[NB-1:0];
  assign rd_ext   = MAX_W'(s1_word);
  assign rpar_all = byte_parity(rd_ext);
  assign rpar     = rpar_all[NB-1:0];
`endif

  // RAM port: clear sweep has priority, out-of-range writes dropped
  always_comb begin
    ram_addr = clearing ? clr_q : address[AW-1:0];
    ram_we   = '0;
    ram_wd   = '0;
    if (clearing) ram_we = '1;
    else if (wr_acc && in_range) ram_we = byteenable;
    if (!clearing) begin
      for (int i = 0; i < NB; i++) begin
`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
        ram_wd[i*LW +: LW] = {wpar[i], writedata[8*i +: 8]};
`else
        ram_wd[i*LW +: LW] = writedata[8*i +: 8];
`endif
      end
    end
  end

  nios_adc_ram_core #(
    .WIDTH (SW),
    .DEPTH (DEPTH),
    .LANES (NB),
    .AW    (AW)
  ) u_core (
    .clk   (clk),
    .ce    (~stall),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wd),
    .rdata (ram_rd)
  );

  // unpack stored lanes into data and stored parity bits
  always_comb begin
    s1_word = '0;
`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
    spar = '0;
`endif
    for (int i = 0; i < NB; i++) begin
      s1_word[8*i +: 8] = ram_rd[i*LW +: 8];
`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
      spar[i] = ram_rd[i*LW + 8];
`endif
    end
  end

  assign s1_data = rng1_q ? s1_word : '0;
`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
  assign s1_mism = rng1_q & (spar != rpar);
`endif

  // read-valid pipeline and range flag, frozen while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      rng1_q <= 1'b0;
    end else if (!stall) begin
      vld_q  <= LAT'({vld_q, rd_acc});
      rng1_q <= in_range;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] d2_q;
`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
    logic m2_q;
`endif
    // optional output register stage
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        d2_q <= '0;
`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
        m2_q <= 1'b0;
`endif
      end else if (!stall) begin
        d2_q <= s1_data;
`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
        m2_q <= s1_mism;
`endif
      end
    end
    assign out_data = d2_q;
`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
    assign out_mism = m2_q;
`endif
  end else begin : g_noreg
    assign out_data = s1_data;
`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
    assign out_mism = s1_mism;
`endif
  end

  assign readdatavalid = vld_q[LAT-1] & ~stall;
  assign readdata      = readdatavalid ? out_data : '0;

`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
  // sticky parity error, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else if (readdatavalid && out_mism) err_q <= 1'b1;
  end
  assign parity_err = err_q | (readdatavalid & out_mism);
`endif

endmodule

// File: tb/tb_nios_adc_onchip_ram_pipelined.sv
// Bench for nios_adc_onchip_ram_pipelined: two instances (OUT_REG 0/1)
// checked against a queue-based model, a vector table and random traffic.
module tb_nios_adc_onchip_ram_pipelined;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int DEPTH = 16;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic [NB-1:0] byteenable = '0;
  logic chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [DW-1:0] writedata = '0;
  logic clken = 1'b1, reset_req = 1'b0;
  logic [DW-1:0] rd0, rd1;
  logic rdv0, rdv1, wt0, wt1, id0, id1;
`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
  logic pe0, pe1;
`endif

  always #5 clk = ~clk;

  nios_adc_onchip_ram_pipelined #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
    .OUT_REG(0), .CLEAR_ON_RESET(1)
  ) u0 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .byteenable(byteenable), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata),
    .readdata(rd0), .readdatavalid(rdv0), .waitrequest(wt0),
    .clken(clken), .reset_req(reset_req), .init_done(id0)
`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
    , .parity_err(pe0)
`endif
  );

  nios_adc_onchip_ram_pipelined #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
    .OUT_REG(1), .CLEAR_ON_RESET(1)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .byteenable(byteenable), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata),
    .readdata(rd1), .readdatavalid(rdv1), .waitrequest(wt1),
    .clken(clken), .reset_req(reset_req), .init_done(id1)
`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
    , .parity_err(pe1)
`endif
  );

  // reference model: word array, cycles of fill done, pending reads
  typedef struct {
    logic [DW-1:0] d;
    int            age;
  } rd_t;

  logic [DW-1:0] mem_m [DEPTH];
  int  clr_m = 0;
  rd_t q0[$];
  rd_t q1[$];
  int  checks = 0;
  int  errors = 0;

  typedef struct {
    logic cs, rd, wr;
    logic [AW-1:0] a;
    logic [NB-1:0] be;
    logic [DW-1:0] wd;
    logic ck, rr;
    logic ew, ev;
    logic [DW-1:0] ed;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit stall_m();
    return !clken || reset_req;
  endfunction

  task automatic check_outs();
    bit w, e0, e1;
    w  = !reset_n || clr_m < DEPTH || stall_m();
    e0 = q0.size() > 0 && q0[0].age == 0 && !stall_m();
    e1 = q1.size() > 0 && q1[0].age == 1 && !stall_m();
    chk("wait_lat1", wt0, w);
    chk("wait_lat2", wt1, w);
    chk("init_lat1", id0, reset_n && clr_m >= DEPTH);
    chk("init_lat2", id1, reset_n && clr_m >= DEPTH);
    chk("rdv_lat1", rdv0, e0);
    chk("rdv_lat2", rdv1, e1);
    if (e0) chk("data_lat1", rd0, q0[0].d);
    if (e1) chk("data_lat2", rd1, q1[0].d);
    if (!reset_n) begin
      chk("rst_data_lat1", rd0, 0);
      chk("rst_data_lat2", rd1, 0);
`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
      chk("rst_perr", {pe1, pe0}, 0);
`endif
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0] d;
    rd_t r;
    if (!reset_n || stall_m()) return;
    if (clr_m < DEPTH) begin
      clr_m++;
      return;
    end
    if (q0.size() > 0 && q0[0].age == 0) void'(q0.pop_front());
    if (q1.size() > 0 && q1[0].age == 1) void'(q1.pop_front());
    foreach (q0[i]) q0[i].age = q0[i].age + 1;
    foreach (q1[i]) q1[i].age = q1[i].age + 1;
    if (chipselect && (read || write)) begin
      if (write) begin
        if (int'(address) < DEPTH)
          for (int b = 0; b < NB; b++)
            if (byteenable[b])
              mem_m[int'(address)][8*b +: 8] = writedata[8*b +: 8];
      end else begin
        d = (int'(address) < DEPTH) ? mem_m[int'(address)] : '0;
        r.d = d;
        r.age = 0;
        q0.push_back(r);
        q1.push_back(r);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outs();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic idle();
    chipselect = 0; read = 0; write = 0;
    clken = 1; reset_req = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    clr_m = 0;
    q0.delete();
    q1.delete();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    repeat (2) cycle();
    reset_n = 1;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (wt1 === 1'b1 && n < 100) begin
      cycle();
      n++;
    end
    chk("init_len", n, DEPTH);
    chk("init_done", id1, 1);
  endtask

  function automatic vec_t mk(input logic cs, rd, wr,
                              input logic [AW-1:0] a,
                              input logic [NB-1:0] be,
                              input logic [DW-1:0] wd,
                              input logic ck, rr, ew, ev,
                              input logic [DW-1:0] ed);
    vec_t v;
    v.cs = cs; v.rd = rd; v.wr = wr; v.a = a; v.be = be;
    v.wd = wd; v.ck = ck; v.rr = rr;
    v.ew = ew; v.ev = ev; v.ed = ed;
    return v;
  endfunction

  initial begin
    // expected columns refer to the OUT_REG=1 instance
    tv.push_back(mk(1,0,1, 3,4'h5,32'hDEADBEEF,1,0, 0,0,0));
    tv.push_back(mk(1,1,0, 3,4'h0,0,1,0, 0,0,0));
    tv.push_back(mk(0,0,0, 0,4'h0,0,1,0, 0,0,0));
    tv.push_back(mk(0,0,0, 0,4'h0,0,1,0, 0,1,32'h00AD00EF));
    tv.push_back(mk(1,0,1, 0,4'hF,32'h10,1,0, 0,0,0));
    tv.push_back(mk(1,0,1, 1,4'hF,32'h11,1,0, 0,0,0));
    tv.push_back(mk(1,0,1, 2,4'hF,32'h12,1,0, 0,0,0));
    tv.push_back(mk(1,0,1, 3,4'hF,32'h13,1,0, 0,0,0));
    tv.push_back(mk(1,1,0, 0,4'h0,0,1,0, 0,0,0));
    tv.push_back(mk(1,1,0, 1,4'h0,0,1,0, 0,0,0));
    tv.push_back(mk(1,1,0, 2,4'h0,0,1,0, 0,1,32'h10));
    tv.push_back(mk(1,1,0, 3,4'h0,0,1,0, 0,1,32'h11));
    tv.push_back(mk(0,0,0, 0,4'h0,0,1,0, 0,1,32'h12));
    tv.push_back(mk(0,0,0, 0,4'h0,0,1,0, 0,1,32'h13));
    tv.push_back(mk(1,1,0, 5,4'h0,0,1,0, 0,0,0));
    tv.push_back(mk(0,0,0, 0,4'h0,0,0,0, 1,0,0));
    tv.push_back(mk(0,0,0, 0,4'h0,0,0,0, 1,0,0));
    tv.push_back(mk(0,0,0, 0,4'h0,0,0,0, 1,0,0));
    tv.push_back(mk(0,0,0, 0,4'h0,0,1,0, 0,0,0));
    tv.push_back(mk(0,0,0, 0,4'h0,0,1,0, 0,1,32'h0));
    tv.push_back(mk(1,1,0, 20,4'h0,0,1,0, 0,0,0));
    tv.push_back(mk(0,0,0, 0,4'h0,0,1,0, 0,0,0));
    tv.push_back(mk(0,0,0, 0,4'h0,0,1,0, 0,1,32'h0));
    tv.push_back(mk(1,0,1, 20,4'hF,32'hFFFFFFFF,1,0, 0,0,0));
    tv.push_back(mk(0,0,0, 0,4'h0,0,1,1, 1,0,0));
    tv.push_back(mk(0,0,0, 0,4'h0,0,1,0, 0,0,0));

    do_reset();
    wait_init();

    // read of address 5 after the fill returns zero
    chipselect = 1; read = 1; address = 5;
    cycle();
    idle();
    repeat (3) cycle();

    foreach (tv[i]) begin
      chipselect = tv[i].cs; read = tv[i].rd; write = tv[i].wr;
      address = tv[i].a; byteenable = tv[i].be;
      writedata = tv[i].wd; clken = tv[i].ck; reset_req = tv[i].rr;
      @(negedge clk);
      check_outs();
      chk($sformatf("vec%0d_wait", i), wt1, tv[i].ew);
      chk($sformatf("vec%0d_rdv", i), rdv1, tv[i].ev);
      if (tv[i].ev) chk($sformatf("vec%0d_data", i), rd1, tv[i].ed);
      @(posedge clk);
      #1;
      model_edge();
    end
    idle();

    // full readback, back to back, after the out-of-range write
    for (int a = 0; a < DEPTH; a++) begin
      chipselect = 1; read = 1; write = 0; address = AW'(a);
      cycle();
    end
    idle();
    repeat (4) cycle();

    // randomized traffic with stalls
    for (int n = 0; n < 500; n++) begin
      chipselect = ($urandom_range(0, 9) < 8);
      read       = $urandom_range(0, 1) == 1;
      write      = $urandom_range(0, 2) == 0;
      address    = AW'($urandom_range(0, 21));
      byteenable = NB'($urandom);
      writedata  = $urandom;
      clken      = $urandom_range(0, 9) != 0;
      reset_req  = $urandom_range(0, 19) == 0;
      cycle();
    end
    idle();
    repeat (4) cycle();

    // reset during an in-flight read, then during the fill
    chipselect = 1; read = 1; address = 3;
    cycle();
    do_reset();
    repeat (5) cycle();
    do_reset();
    wait_init();

`ifdef NIOS_ADC_ONCHIP_RAM_PARITY_EN
    chipselect = 1; write = 1; address = 7;
    byteenable = '1; writedata = 32'hA5A5A5A5;
    cycle();
    idle();
    cycle();
    u0.u_core.mem_q[7][8] = ~u0.u_core.mem_q[7][8];
    u1.u_core.mem_q[7][8] = ~u1.u_core.mem_q[7][8];
    chk("perr_before", {pe1, pe0}, 0);
    chipselect = 1; read = 1; address = 7;
    cycle();
    idle();
    @(negedge clk);
    chk("perr_lat1_on_rdv", {rdv0, pe0}, 2'b11);
    @(posedge clk);
    #1;
    model_edge();
    @(negedge clk);
    chk("perr_lat2_on_rdv", {rdv1, pe1}, 2'b11);
    @(posedge clk);
    #1;
    model_edge();
    repeat (3) cycle();
    chk("perr_sticky", {pe1, pe0}, 2'b11);
    do_reset();
    chk("perr_cleared", {pe1, pe0}, 0);
    wait_init();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
